// File: rtl/matrix_subtractor_if.sv
// Operand/result bundle between the matrix operation controller and the subtractor.
// Matrices are packed row-major, element k at bits [k*ELEM_W +: ELEM_W].
interface matrix_subtractor_if #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5
);
    localparam int NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int BUS_W    = NUM_ELEM * ELEM_W;

    logic             start;
    logic [BUS_W-1:0] matrix_a;
    logic [BUS_W-1:0] matrix_b;
    logic [1:0]       matrix_size;
    logic [BUS_W-1:0] result_out;
    logic             overflow;
    logic             done;

    modport master (
        output start,
        output matrix_a,
        output matrix_b,
        output matrix_size,
        input  result_out,
        input  overflow,
        input  done
    );

    modport slave (
        input  start,
        input  matrix_a,
        input  matrix_b,
        input  matrix_size,
        output result_out,
        output overflow,
        output done
    );
endinterface

// File: rtl/matrix_subtractor.sv
// Element-wise signed A - B for square matrices of dimension 2..MAX_DIM.
// One registered stage: operands sampled on start, result/overflow/done registered together.
module matrix_subtractor #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic               clk,
    input  logic               rst,
    matrix_subtractor_if.slave bus
);
    localparam int NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int BUS_W    = NUM_ELEM * ELEM_W;

    logic [ELEM_W:0]   diff     [NUM_ELEM];
    logic [NUM_ELEM-1:0] elem_ovf;
    logic [NUM_ELEM-1:0] active_mask;

    logic [BUS_W-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;
    logic             done_d, done_q;

    // One sign-extended subtractor per slot; the extra bit exposes overflow.
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_sub
        logic [ELEM_W-1:0] a_elem;
        logic [ELEM_W-1:0] b_elem;

        assign a_elem      = bus.matrix_a[k*ELEM_W +: ELEM_W];
        assign b_elem      = bus.matrix_b[k*ELEM_W +: ELEM_W];
        assign diff[k]     = {a_elem[ELEM_W-1], a_elem} - {b_elem[ELEM_W-1], b_elem};
        assign elem_ovf[k] = diff[k][ELEM_W] ^ diff[k][ELEM_W-1];
    end

    // Active elements are packed contiguously from slot 0, no row stride.
    always_comb begin
        int unsigned dim;
        int unsigned active_cnt;
        dim        = int'(bus.matrix_size) + 2;
        active_cnt = dim * dim;
        for (int k = 0; k < NUM_ELEM; k++) begin
            active_mask[k] = (k < active_cnt);
        end
    end

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        if (bus.start) begin
            done_d     = 1'b1;
            overflow_d = |(elem_ovf & active_mask);
            for (int k = 0; k < NUM_ELEM; k++) begin
                result_d[k*ELEM_W +: ELEM_W] = active_mask[k] ? diff[k][ELEM_W-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register updates from pre-edge values.
        if (rst) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus.result_out = result_q;
    assign bus.overflow   = overflow_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_matrix_subtractor.sv
// Self-checking bench for matrix_subtractor: directed scenarios plus a randomized
// scoreboard against an integer-arithmetic reference model.
module tb_matrix_subtractor;
    localparam int EW    = 8;
    localparam int MD    = 5;
    localparam int NE    = MD * MD;
    localparam int BW    = NE * EW;
    localparam int CMP_W = BW + 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    matrix_subtractor_if #(.ELEM_W(EW), .MAX_DIM(MD)) m_if ();

    matrix_subtractor #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    always #5 clk = ~clk;

    // Reference: integer subtraction, range test on the true difference.
    function automatic logic [BW:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          input logic [1:0] size);
        logic [BW-1:0] r;
        logic          ovf;
        int            n;
        int            d;
        logic [31:0]   dv;
        r   = '0;
        ovf = 1'b0;
        n   = int'(size) + 2;
        for (int k = 0; k < n * n; k++) begin
            d  = int'($signed(a[k*EW +: EW])) - int'($signed(b[k*EW +: EW]));
            dv = d;
            r[k*EW +: EW] = dv[EW-1:0];
            if (d > 127 || d < -128) ovf = 1'b1;
        end
        return {ovf, r};
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] v;
        for (int k = 0; k < NE; k++) v[k*EW +: EW] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [1:0] size);
        m_if.start       = s;
        m_if.matrix_a    = a;
        m_if.matrix_b    = b;
        m_if.matrix_size = size;
    endtask

    task automatic test_reset();
        logic [CMP_W-1:0] obs;
        logic [CMP_W-1:0] exp_v;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rand_bus(), rand_bus(), 2'($urandom_range(0, 3)));
            step();
            obs   = {m_if.done, m_if.overflow, m_if.result_out};
            exp_v = '0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_asserted cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        rst = 1'b0;
        drive(1'b0, rand_bus(), rand_bus(), 2'b11);
        step();
        obs   = {m_if.done, m_if.overflow, m_if.result_out};
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_release_hold: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_2x2();
        logic [BW-1:0] a, b, exp_r;
        int av[4] = '{10, 20, 30, 40};
        int bv[4] = '{5, 10, 15, 20};
        int rv[4] = '{5, 10, 15, 20};
        a = '0; b = '0; exp_r = '0;
        for (int k = 0; k < 4; k++) begin
            a[k*EW +: EW]     = 8'(av[k]);
            b[k*EW +: EW]     = 8'(bv[k]);
            exp_r[k*EW +: EW] = 8'(rv[k]);
        end
        drive(1'b1, a, b, 2'b00);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b1, 1'b0, exp_r}) begin
            errors++;
            $display("FAIL 2x2_result: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b1, 1'b0, exp_r});
        end
        drive(1'b0, a, b, 2'b00);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b0, 1'b0, exp_r}) begin
            errors++;
            $display("FAIL 2x2_done_pulse: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b0, 1'b0, exp_r});
        end
    endtask

    task automatic test_3x3_overflow();
        logic [BW-1:0] a, b, exp_r;
        int av[9] = '{-128, 100, 50, 30, 20, 10, 5, 0, -10};
        int bv[9] = '{1, 10, 20, 10, 5, 2, 1, -5, -20};
        int rv[9] = '{127, 90, 30, 20, 15, 8, 4, 5, 10};
        a = rand_bus(); b = rand_bus(); exp_r = '0;
        for (int k = 0; k < 9; k++) begin
            a[k*EW +: EW]     = 8'(av[k]);
            b[k*EW +: EW]     = 8'(bv[k]);
            exp_r[k*EW +: EW] = 8'(rv[k]);
        end
        drive(1'b1, a, b, 2'b01);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b1, 1'b1, exp_r}) begin
            errors++;
            $display("FAIL 3x3_overflow: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b1, 1'b1, exp_r});
        end
    endtask

    task automatic test_5x5();
        logic [BW-1:0] a, b, exp_r;
        for (int k = 0; k < NE; k++) begin
            a[k*EW +: EW]     = 8'(k + 10);
            b[k*EW +: EW]     = 8'(k);
            exp_r[k*EW +: EW] = 8'd10;
        end
        drive(1'b1, a, b, 2'b11);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b1, 1'b0, exp_r}) begin
            errors++;
            $display("FAIL 5x5_full: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b1, 1'b0, exp_r});
        end
    endtask

    task automatic test_inactive_mask();
        logic [BW-1:0] a, b, exp_r;
        a = '0; b = '0; exp_r = '0;
        a[4*EW +: EW] = 8'h80;
        b[4*EW +: EW] = 8'h01;
        drive(1'b1, a, b, 2'b00);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b1, 1'b0, exp_r}) begin
            errors++;
            $display("FAIL mask_2x2_slot4: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b1, 1'b0, exp_r});
        end
        exp_r[4*EW +: EW] = 8'h7f;
        drive(1'b1, a, b, 2'b01);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b1, 1'b1, exp_r}) begin
            errors++;
            $display("FAIL mask_3x3_slot4: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b1, 1'b1, exp_r});
        end
        // Garbage in every inactive slot of a 4x4 must not leak into result or overflow.
        a = rand_bus(); b = rand_bus();
        for (int k = 0; k < 16; k++) begin
            a[k*EW +: EW] = 8'($urandom_range(0, 60));
            b[k*EW +: EW] = 8'($urandom_range(0, 60));
        end
        drive(1'b1, a, b, 2'b10);
        step();
        checks++;
        if ({m_if.overflow, m_if.result_out} !== model(a, b, 2'b10)) begin
            errors++;
            $display("FAIL mask_4x4_garbage: got %h expected %h",
                     {m_if.overflow, m_if.result_out}, model(a, b, 2'b10));
        end
    endtask

    task automatic test_hold_and_priority();
        logic [BW-1:0] a, b;
        logic [BW:0]   held;
        a = rand_bus(); b = rand_bus();
        drive(1'b1, a, b, 2'b11);
        step();
        held = model(a, b, 2'b11);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rand_bus(), rand_bus(), 2'($urandom_range(0, 3)));
            step();
            checks++;
            if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b0, held}) begin
                errors++;
                $display("FAIL hold_idle cycle %0d: got %h expected %h", i,
                         {m_if.done, m_if.overflow, m_if.result_out}, {1'b0, held});
            end
        end
        rst = 1'b1;
        drive(1'b1, rand_bus(), rand_bus(), 2'b11);
        step();
        rst = 1'b0;
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== '0) begin
            errors++;
            $display("FAIL rst_over_start: got %h expected 0",
                     {m_if.done, m_if.overflow, m_if.result_out});
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] a, b;
        logic [BW:0]   exp_v;
        b = rand_bus();
        for (int i = 0; i < 3; i++) begin
            a = rand_bus();
            drive(1'b1, a, b, 2'b11);
            step();
            exp_v = model(a, b, 2'b11);
            checks++;
            if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b1, exp_v}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i,
                         {m_if.done, m_if.overflow, m_if.result_out}, {1'b1, exp_v});
            end
        end
        drive(1'b0, rand_bus(), b, 2'b00);
        step();
        checks++;
        if ({m_if.done, m_if.overflow, m_if.result_out} !== {1'b0, exp_v}) begin
            errors++;
            $display("FAIL back_to_back_release: got %h expected %h",
                     {m_if.done, m_if.overflow, m_if.result_out}, {1'b0, exp_v});
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] a, b;
        logic [1:0]    size;
        logic          s;
        logic [BW:0]   sb_state;
        logic          sb_done;
        sb_state = {m_if.overflow, m_if.result_out};
        for (int i = 0; i < 200; i++) begin
            a    = rand_bus();
            b    = rand_bus();
            size = 2'($urandom_range(0, 3));
            s    = ($urandom_range(0, 3) != 0);
            drive(s, a, b, size);
            step();
            if (s) sb_state = model(a, b, size);
            sb_done = s;
            checks++;
            if ({m_if.done, m_if.overflow, m_if.result_out} !== {sb_done, sb_state}) begin
                errors++;
                $display("FAIL random iter %0d size %0d: got %h expected %h", i, size,
                         {m_if.done, m_if.overflow, m_if.result_out}, {sb_done, sb_state});
            end
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        drive(1'b0, '0, '0, 2'b00);

        test_reset();
        test_2x2();
        test_3x3_overflow();
        test_5x5();
        test_inactive_mask();
        test_hold_and_priority();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
